// File: rtl/grain_pkg.sv
// Shared constants and types for the wide Grain-128 NFSR.
// Build option: define GRAIN128A_EN to add the Grain-128a feedback terms.
package grain_pkg;

   // NFSR length in bits; b0 is the oldest (next to leave) bit.
   localparam int NFSR_LEN = 128;

   // Widest supported step count: with W <= 32 the highest tap (96 + 31)
   // still lands inside the current state, so every slice reads pre-shift bits.
   localparam int MAX_W = 32;

   // Linear taps of g(): b0, b26, b56, b91, b96.
   localparam int N_LIN = 5;
   localparam int LIN_TAPS [N_LIN] = '{0, 26, 56, 91, 96};

   // Two-input AND terms of g(): b[PAIR_A[i]] & b[PAIR_B[i]].
   localparam int N_PAIR = 7;
   localparam int PAIR_A [N_PAIR] = '{3, 11, 17, 27, 40, 61, 68};
   localparam int PAIR_B [N_PAIR] = '{67, 13, 18, 59, 48, 65, 84};

`ifdef GRAIN128A_EN
   // Grain-128a extras: one four-input AND and two three-input ANDs.
   localparam int N_QUAD = 4;
   localparam int QUAD_TAPS [N_QUAD] = '{88, 92, 93, 95};
   localparam int N_TRI = 2;
   localparam int TRI_TAPS [N_TRI][3] = '{'{22, 24, 25}, '{70, 78, 82}};
`endif

   // Sequencing states of the NFSR.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      RUN  = 2'd2
   } nfsr_state_e;

   // True for the supported steps-per-clock values (powers of two up to MAX_W).
   function automatic bit legal_w(int w);
      return (w == 1) || (w == 2) || (w == 4) || (w == 8) ||
             (w == 16) || (w == MAX_W);
   endfunction

endpackage

// File: rtl/grain_nfsr_fb.sv
// Single-step Grain NFSR feedback g() for step offset J, read from the
// un-shifted state so W copies can run side by side in one clock.
// Build option: GRAIN128A_EN adds the Grain-128a nonlinear terms.
module grain_nfsr_fb
   import grain_pkg::*;
#(
   parameter int J = 0
) (
   input  logic [127:0] state,
   input  logic         lfsr_bit,
   output logic         fb
);

   logic [N_LIN-1:0]  lin_t;
   logic [N_PAIR-1:0] pair_t;
   logic              extra_t;

   // Only a subset of the state feeds any one slice.
   logic unused_state;
   assign unused_state = ^state;

   for (genvar i = 0; i < N_LIN; i++) begin : g_lin
      assign lin_t[i] = state[LIN_TAPS[i] + J];
   end

   for (genvar i = 0; i < N_PAIR; i++) begin : g_pair
      assign pair_t[i] = state[PAIR_A[i] + J] & state[PAIR_B[i] + J];
   end

`ifdef GRAIN128A_EN
   logic             quad_t;
   logic [N_TRI-1:0] tri_t;

   assign quad_t = state[QUAD_TAPS[0] + J] & state[QUAD_TAPS[1] + J] &
                   state[QUAD_TAPS[2] + J] & state[QUAD_TAPS[3] + J];

   for (genvar i = 0; i < N_TRI; i++) begin : g_tri
      assign tri_t[i] = state[TRI_TAPS[i][0] + J] & state[TRI_TAPS[i][1] + J] &
                        state[TRI_TAPS[i][2] + J];
   end

   assign extra_t = quad_t ^ (^tri_t);
`else
   assign extra_t = 1'b0;
`endif

   // Feedback bit: LFSR input plus all linear and product terms.
   always_comb begin
      fb = lfsr_bit ^ (^lin_t) ^ (^pair_t) ^ extra_t;
   end

endmodule

// File: rtl/grain_nfsr_wide.sv
// Grain-128 NFSR advancing W bit-steps per clock, with its own key load and
// initialisation sequencing (IDLE -> INIT -> RUN).
// Build option: GRAIN128A_EN switches the feedback to the Grain-128a NFSR.
module grain_nfsr_wide
   import grain_pkg::*;
#(
   parameter int W           = 1,
   parameter int INIT_ROUNDS = 256
) (
   input  logic         clk,
   input  logic         n_reset,
   input  logic         load,
   input  logic [127:0] key_in,
   input  logic [W-1:0] lfsr_in,
   input  logic [W-1:0] ks_in,
   input  logic         advance,
   output logic [127:0] data,
   output logic [W-1:0] nbits,
   output logic         init_active,
   output logic         ready,
   output logic         init_done
);

   // Initialisation takes INIT_ROUNDS bit-steps, i.e. INIT_CLKS clocks.
   localparam int INIT_CLKS = INIT_ROUNDS / W;
   localparam int CNT_W     = $clog2(INIT_CLKS) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(INIT_CLKS - 1);

   if (!legal_w(W) || (INIT_ROUNDS % W) != 0 || INIT_ROUNDS < W) begin : g_bad_cfg
      $error("grain_nfsr_wide: W must be 1,2,4,8,16 or 32 and divide INIT_ROUNDS");
   end

   nfsr_state_e           state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [NFSR_LEN-1:0]   data_q, data_d;
   logic                  init_done_q, init_done_d;
   logic [W-1:0]          g;
   logic                  shift;

   // Slice j computes the feedback for bit-step j from the current state;
   // its result lands at index NFSR_LEN-W+j after the shift.
   for (genvar j = 0; j < W; j++) begin : g_slice
      grain_nfsr_fb #(.J(j)) u_fb (
         .state    (data_q),
         .lfsr_bit (lfsr_in[j]),
         .fb       (g[j])
      );
   end

   // Keystream is fed back only during initialisation.
   always_comb begin
      nbits = g ^ ((state_q == INIT) ? ks_in : '0);
   end

   // Next-state logic: load overrides everything, then per-state shift control.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      data_d      = data_q;
      init_done_d = 1'b0;
      shift       = 1'b0;

      if (load) begin
         data_d  = key_in;
         cnt_d   = '0;
         state_d = INIT;
      end else begin
         case (state_q)
            IDLE: begin
               shift = 1'b0;
            end
            INIT: begin
               shift = 1'b1;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_CNT) begin
                  state_d     = RUN;
                  init_done_d = 1'b1;
               end
            end
            RUN: begin
               shift = advance;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      if (shift) begin
         data_d = {nbits, data_q[NFSR_LEN-1:W]};
      end
   end

   // State, counter, NFSR contents and completion pulse registers.
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         data_q      <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         data_q      <= data_d;
         init_done_q <= init_done_d;
      end
   end

   assign data        = data_q;
   assign init_active = (state_q == INIT);
   assign ready       = (state_q == RUN);
   assign init_done   = init_done_q;

endmodule
